// File: rtl/data_cache_pkg.sv
// Shared constants and state encoding for the direct-mapped data cache.
package data_cache_pkg;

    localparam int DC_WORD_SIZE   = 16;
    localparam int DC_CACHE_LINES = 4;
    localparam int DC_LINE_WORDS  = 4;
    localparam int DC_OFFSET_W    = $clog2(DC_LINE_WORDS);
    localparam int DC_INDEX_W     = $clog2(DC_CACHE_LINES);
    localparam int DC_TAG_W       = DC_WORD_SIZE - DC_INDEX_W - DC_OFFSET_W;

    typedef enum logic [1:0] {
        DC_IDLE  = 2'd0,
        DC_FILL  = 2'd1,
        DC_WRITE = 2'd2
    } dc_state_e;

endpackage

// File: rtl/data_cache_line_array.sv
// Valid/tag/data storage: combinational read, synchronous fill and word write.
module cache_line_array #(
    parameter int W     = 16,
    parameter int LINES = 4,
    parameter int WORDS = 4,
    parameter int IDX_W = 2,
    parameter int OFF_W = 2,
    parameter int TAG_W = 12
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic [OFF_W-1:0]   rd_off,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [W-1:0]       rd_word,
    input  logic               fill_en,
    input  logic [IDX_W-1:0]   fill_idx,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [W*WORDS-1:0] fill_line,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [OFF_W-1:0]   wr_off,
    input  logic [W-1:0]       wr_data
);

    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [TAG_W-1:0]   tag_d  [LINES];
    logic [W*WORDS-1:0] data_q [LINES];
    logic [W*WORDS-1:0] data_d [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_off*W +: W];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
            tag_d[fill_idx]   = fill_tag;
            data_d[fill_idx]  = fill_line;
        end
        if (wr_en) begin
            data_d[wr_idx][wr_off*W +: W] = wr_data;
        end
        // Only valid bits need clearing; stale tags/data are unreachable.
        if (clr) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        tag_q   <= tag_d;
        data_q  <= data_d;
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache for the MEM stage.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int WORD_SIZE  = DC_WORD_SIZE,
    parameter int NUM_LINES  = DC_CACHE_LINES,
    parameter int LINE_WORDS = DC_LINE_WORDS
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          c_read,
    input  logic                          c_write,
    input  logic [WORD_SIZE-1:0]          c_addr,
    input  logic [WORD_SIZE-1:0]          c_wdata,
    output logic [WORD_SIZE-1:0]          c_rdata,
    output logic                          c_done,
    output logic                          m_read,
    output logic                          m_write,
    output logic [WORD_SIZE-1:0]          m_addr,
    output logic [WORD_SIZE-1:0]          m_wdata,
    input  logic [WORD_SIZE*LINE_WORDS-1:0] m_rdata,
    input  logic                          m_ack,
    output logic [WORD_SIZE-1:0]          access_count,
    output logic [WORD_SIZE-1:0]          hit_count
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;

    dc_state_e state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 hit_q, hit_d;
    logic                 refill_q, refill_d;
    logic [WORD_SIZE-1:0] acc_q, acc_d;
    logic [WORD_SIZE-1:0] hcnt_q, hcnt_d;
    logic                 mrd_q, mrd_d;
    logic                 mwr_q, mwr_d;
    logic [WORD_SIZE-1:0] maddr_q, maddr_d;
    logic [WORD_SIZE-1:0] mwdata_q, mwdata_d;

    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [WORD_SIZE-1:0] rd_word;
    logic                 hit;
    logic                 fill_en;
    logic                 wr_en;

    cache_line_array #(
        .W    (WORD_SIZE),
        .LINES(NUM_LINES),
        .WORDS(LINE_WORDS),
        .IDX_W(IDX_W),
        .OFF_W(OFF_W),
        .TAG_W(TAG_W)
    ) u_lines (
        .clk      (Clk),
        .clr      (Reset),
        .rd_idx   (c_addr[OFF_W +: IDX_W]),
        .rd_off   (c_addr[OFF_W-1:0]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_word  (rd_word),
        .fill_en  (fill_en),
        .fill_idx (addr_q[OFF_W +: IDX_W]),
        .fill_tag (addr_q[WORD_SIZE-1 -: TAG_W]),
        .fill_line(m_rdata),
        .wr_en    (wr_en),
        .wr_idx   (addr_q[OFF_W +: IDX_W]),
        .wr_off   (addr_q[OFF_W-1:0]),
        .wr_data  (wdata_q)
    );

    assign hit          = rd_valid && (rd_tag == c_addr[WORD_SIZE-1 -: TAG_W]);
    assign m_read       = mrd_q;
    assign m_write      = mwr_q;
    assign m_addr       = maddr_q;
    assign m_wdata      = mwdata_q;
    assign access_count = acc_q;
    assign hit_count    = hcnt_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hit_d    = hit_q;
        refill_d = refill_q;
        acc_d    = acc_q;
        hcnt_d   = hcnt_q;
        mrd_d    = mrd_q;
        mwr_d    = mwr_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        c_done   = 1'b0;
        c_rdata  = '0;
        fill_en  = 1'b0;
        wr_en    = 1'b0;
        unique case (state_q)
            DC_IDLE: begin
                if (c_write) begin
                    state_d  = DC_WRITE;
                    addr_d   = c_addr;
                    wdata_d  = c_wdata;
                    hit_d    = hit;
                    mwr_d    = 1'b1;
                    maddr_d  = c_addr;
                    mwdata_d = c_wdata;
                end else if (c_read && hit) begin
                    c_done   = 1'b1;
                    c_rdata  = rd_word;
                    acc_d    = acc_q + 1'b1;
                    // A hit that follows our own fill is not a true hit.
                    if (!refill_q) hcnt_d = hcnt_q + 1'b1;
                    refill_d = 1'b0;
                end else if (c_read) begin
                    state_d = DC_FILL;
                    addr_d  = c_addr;
                    mrd_d   = 1'b1;
                    maddr_d = {c_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                end
            end
            DC_FILL: begin
                if (m_ack) begin
                    state_d  = DC_IDLE;
                    fill_en  = 1'b1;
                    refill_d = 1'b1;
                    mrd_d    = 1'b0;
                    maddr_d  = '0;
                end
            end
            DC_WRITE: begin
                if (m_ack) begin
                    state_d  = DC_IDLE;
                    c_done   = 1'b1;
                    wr_en    = hit_q;
                    acc_d    = acc_q + 1'b1;
                    if (hit_q) hcnt_d = hcnt_q + 1'b1;
                    refill_d = 1'b0;
                    mwr_d    = 1'b0;
                    maddr_d  = '0;
                    mwdata_d = '0;
                end
            end
            default: state_d = DC_IDLE;
        endcase
        if (Reset) begin
            c_done  = 1'b0;
            c_rdata = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= DC_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            hit_q    <= 1'b0;
            refill_q <= 1'b0;
            acc_q    <= '0;
            hcnt_q   <= '0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            hit_q    <= hit_d;
            refill_q <= refill_d;
            acc_q    <= acc_d;
            hcnt_q   <= hcnt_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache with a latency-3 memory responder.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        Reset;
    logic        c_read, c_write;
    logic [15:0] c_addr, c_wdata, c_rdata;
    logic        c_done, m_read, m_write;
    logic [15:0] m_addr, m_wdata;
    logic [63:0] m_rdata;
    logic        m_ack;
    logic [15:0] access_count, hit_count;

    data_cache dut (
        .Clk(clk), .Reset(Reset),
        .c_read(c_read), .c_write(c_write),
        .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_done(c_done),
        .m_read(m_read), .m_write(m_write),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .access_count(access_count), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        bit          wr;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mem [logic [15:0]];
    bit          auto_ack = 1'b1;
    int          n_mread = 0;
    int          n_mwrite = 0;
    logic [15:0] last_maddr, last_mwdata;
    bit          m_valid [4];
    logic [11:0] m_tag [4];
    int          exp_acc = 0;
    int          exp_hit = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mget(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 16'h0003) ^ 16'h5A5A;
    endfunction

    // Memory: ack 3 cycles after the request first appears.
    initial begin
        int cnt = 0;
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!auto_ack || Reset) begin
                cnt = 0;
            end else if (m_ack) begin
                m_ack = 1'b0;
                m_rdata = '0;
                cnt = 0;
            end else if (m_read || m_write) begin
                if (cnt == 3) begin
                    m_ack = 1'b1;
                    last_maddr = m_addr;
                    if (m_read) begin
                        n_mread++;
                        for (int k = 0; k < 4; k++)
                            m_rdata[16*k +: 16] = mget({m_addr[15:2], 2'(k)});
                    end else begin
                        n_mwrite++;
                        last_mwdata = m_wdata;
                        mem[m_addr] = m_wdata;
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic access(input bit wr, input logic [15:0] a,
                          input logic [15:0] d);
        exp_t e, got_e;
        bit   hit, done;
        int   nr0, nw0;
        hit = m_valid[a[3:2]] && (m_tag[a[3:2]] == a[15:4]);
        e.wr = wr;
        e.rdata = wr ? 16'h0 : (a == 16'h0 ? mget(a) : mget(a));
        sb_q.push_back(e);
        nr0 = n_mread;
        nw0 = n_mwrite;
        @(posedge clk);
        #1;
        c_read = !wr;
        c_write = wr;
        c_addr = a;
        c_wdata = d;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (c_done) begin
                done = 1'b1;
                break;
            end
        end
        got_e = sb_q.pop_front();
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("ack_at_done", {31'd0, m_ack}, {31'd0, got_e.wr});
            if (!got_e.wr) check("rdata", {16'd0, c_rdata}, {16'd0, got_e.rdata});
        end
        @(posedge clk);
        #1;
        c_read = 1'b0;
        c_write = 1'b0;
        exp_acc++;
        if (hit) exp_hit++;
        if (!wr && !hit) begin
            m_valid[a[3:2]] = 1'b1;
            m_tag[a[3:2]] = a[15:4];
        end
        check("access_count", {16'd0, access_count}, 32'(exp_acc & 16'hFFFF));
        check("hit_count", {16'd0, hit_count}, 32'(exp_hit & 16'hFFFF));
        if (wr) begin
            check("mwrite_n", 32'(n_mwrite - nw0), 32'd1);
            check("mwrite_addr", {16'd0, last_maddr}, {16'd0, a});
            check("mwrite_data", {16'd0, last_mwdata}, {16'd0, d});
        end else begin
            check("mread_n", 32'(n_mread - nr0), hit ? 32'd0 : 32'd1);
            if (!hit) check("fill_addr", {16'd0, last_maddr}, {16'd0, a[15:2], 2'b00});
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        exp_acc = 0;
        exp_hit = 0;
    endtask

    initial begin
        Reset = 1'b1;
        c_read = 1'b0;
        c_write = 1'b0;
        c_addr = '0;
        c_wdata = '0;
        mem[16'h0010] = 16'h00A0;
        mem[16'h0011] = 16'h00B1;
        mem[16'h0012] = 16'h00C2;
        mem[16'h0013] = 16'h00D3;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        @(negedge clk);
        check("rst_acc", {16'd0, access_count}, 32'd0);
        check("rst_hit", {16'd0, hit_count}, 32'd0);
        check("rst_mread", {31'd0, m_read}, 32'd0);
        check("rst_mwrite", {31'd0, m_write}, 32'd0);
        check("rst_maddr", {16'd0, m_addr}, 32'd0);
        check("rst_done", {31'd0, c_done}, 32'd0);

        access(1'b0, 16'h0012, 16'h0);
        access(1'b0, 16'h0013, 16'h0);
        access(1'b1, 16'h0011, 16'hBEEF);
        access(1'b0, 16'h0011, 16'h0);
        access(1'b1, 16'h0040, 16'h1234);
        access(1'b0, 16'h0040, 16'h0);
        access(1'b0, 16'h0010, 16'h0);
        access(1'b0, 16'h0110, 16'h0);
        access(1'b0, 16'h0010, 16'h0);

        for (int n = 0; n < 30; n++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) a = a | 16'h0100;
            access($urandom_range(0, 2) == 0, a, 16'($urandom));
        end

        auto_ack = 1'b0;
        @(posedge clk);
        #1;
        c_read = 1'b1;
        c_addr = 16'h0200;
        @(negedge clk);
        @(negedge clk);
        check("fill_req", {31'd0, m_read}, 32'd1);
        @(posedge clk);
        #1;
        Reset = 1'b1;
        c_read = 1'b0;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        reset_model();
        @(negedge clk);
        check("mr_after_rst", {31'd0, m_read}, 32'd0);
        check("acc_after_rst", {16'd0, access_count}, 32'd0);
        check("hit_after_rst", {16'd0, hit_count}, 32'd0);
        m_ack = 1'b1;
        m_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        check("late_ack_done", {31'd0, c_done}, 32'd0);
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        m_rdata = '0;
        @(negedge clk);
        check("late_ack_mread", {31'd0, m_read}, 32'd0);
        check("late_ack_acc", {16'd0, access_count}, 32'd0);
        auto_ack = 1'b1;
        access(1'b0, 16'h0200, 16'h0);
        access(1'b0, 16'h0201, 16'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
